// File: rtl/operand_collector_pkg.sv
// Shared types and defaults for the operand collector.
// Holds the collector state encoding and a helper that derives it from fill flags.
package opcol_pkg;

    localparam int unsigned OC_WIDTH_DEF = 8;
    localparam int unsigned OC_DEPTH_DEF = 3;
    localparam int unsigned OC_PC_W_DEF  = 12;

    typedef enum logic [1:0] {
        OC_EMPTY   = 2'd0,
        OC_PARTIAL = 2'd1,
        OC_FULL    = 2'd2
    } oc_state_e;

    function automatic oc_state_e fill_to_state(input logic is_full, input logic is_empty);
        oc_state_e st;
        if (is_full) begin
            st = OC_FULL;
        end else if (is_empty) begin
            st = OC_EMPTY;
        end else begin
            st = OC_PARTIAL;
        end
        return st;
    endfunction

endpackage

// File: rtl/operand_collector_if.sv
// Request/response bundle of the operand collector.
// The master drives the put/op requests; the slave returns the slot contents and status.
interface operand_collector_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned PC_W  = 12
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                     put_en;
    logic                     op_en;
    logic [WIDTH-1:0]         value;
    logic [PC_W-1:0]          prog_ctr;
    logic [DEPTH*WIDTH-1:0]   slots;
    logic [DEPTH-1:0]         valid;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;
    logic                     overflow;
    logic [1:0]               state;

    modport master (
        output put_en, op_en, value, prog_ctr,
        input  slots, valid, count, full, empty, overflow, state
    );

    modport slave (
        input  put_en, op_en, value, prog_ctr,
        output slots, valid, count, full, empty, overflow, state
    );

endinterface

// File: rtl/operand_collector_pc_change_detect.sv
// Flags an event cycle when prog_ctr differs from the last accepted value,
// or on the first edge after reset; every event records the current prog_ctr.
module pc_change_detect #(
    parameter int unsigned PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] prog_ctr,
    output logic            new_pc
);

    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            pc_set_q, pc_set_d;

    // Plain inequality covers the all-ones to zero wrap as well.
    assign new_pc = !pc_set_q || (prog_ctr != last_pc_q);

    always_comb begin
        last_pc_d = last_pc_q;
        pc_set_d  = pc_set_q;
        if (new_pc) begin
            last_pc_d = prog_ctr;
            pc_set_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc_q <= '0;
            pc_set_q  <= 1'b0;
        end else begin
            last_pc_q <= last_pc_d;
            pc_set_q  <= pc_set_d;
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Collects operands into ascending slots and releases them all on an op request.
// Define OPERAND_COLLECTOR_PCGATE_EN to accept events only when prog_ctr changes.
module operand_collector
    import opcol_pkg::*;
#(
    parameter int unsigned WIDTH = OC_WIDTH_DEF,
    parameter int unsigned DEPTH = OC_DEPTH_DEF,
    parameter int unsigned PC_W  = OC_PC_W_DEF
) (
    input logic clk,
    input logic reset,
    operand_collector_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic event_en;

`ifdef OPERAND_COLLECTOR_PCGATE_EN
    pc_change_detect #(
        .PC_W(PC_W)
    ) u_pc_change_detect (
        .clk     (clk),
        .reset   (reset),
        .prog_ctr(bus.prog_ctr),
        .new_pc  (event_en)
    );
`else
    logic unused_prog_ctr;
    assign unused_prog_ctr = ^bus.prog_ctr;
    assign event_en        = 1'b1;
`endif

    logic [DEPTH*WIDTH-1:0] slots_q, slots_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    oc_state_e              state_q, state_d;
    logic [CW-1:0]          base_cnt;

    always_comb begin
        slots_d    = slots_q;
        valid_d    = valid_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        base_cnt   = count_q;
        if (event_en) begin
            // The op is applied before the put so a combined request restarts at slot 0.
            if (bus.op_en) begin
                valid_d    = '0;
                base_cnt   = '0;
                count_d    = '0;
                overflow_d = 1'b0;
            end
            if (bus.put_en) begin
                if (base_cnt < CW'(DEPTH)) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (CW'(i) == base_cnt) begin
                            slots_d[i*WIDTH +: WIDTH] = bus.value;
                            valid_d[i]                = 1'b1;
                        end
                    end
                    count_d = base_cnt + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        state_d = fill_to_state(full_d, empty_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slots_q    <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            state_q    <= OC_EMPTY;
        end else begin
            slots_q    <= slots_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            state_q    <= state_d;
        end
    end

    assign bus.slots    = slots_q;
    assign bus.valid    = valid_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed self-checking bench for operand_collector (default and 16x1 configurations).
module tb_operand_collector;
    import opcol_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    operand_collector_if #(.WIDTH(8),  .DEPTH(3), .PC_W(12)) ifa ();
    operand_collector_if #(.WIDTH(16), .DEPTH(1), .PC_W(12)) ifb ();

    operand_collector #(
        .WIDTH(8),
        .DEPTH(3),
        .PC_W (12)
    ) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (ifa.slave)
    );

    operand_collector #(
        .WIDTH(16),
        .DEPTH(1),
        .PC_W (12)
    ) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (ifb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic put, input logic op, input logic [7:0] v,
                          input logic [11:0] pc);
        ifa.put_en   = put;
        ifa.op_en    = op;
        ifa.value    = v;
        ifa.prog_ctr = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic put, input logic op, input logic [15:0] v,
                          input logic [11:0] pc);
        ifb.put_en   = put;
        ifb.op_en    = op;
        ifb.value    = v;
        ifb.prog_ctr = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        ifb.put_en   = 1'b0;
        ifb.op_en    = 1'b0;
        ifb.value    = '0;
        ifb.prog_ctr = '0;

        // Reset wins over a simultaneous put.
        step_a(1'b1, 1'b0, 8'hAA, 12'd0);
        chk("rst_valid", 64'(ifa.valid), 64'h0);
        chk("rst_count", 64'(ifa.count), 64'h0);
        chk("rst_slots", 64'(ifa.slots), 64'h0);
        chk("rst_ovf", 64'(ifa.overflow), 64'h0);
        chk("rst_state", 64'(ifa.state), 64'(OC_EMPTY));
        chk("rst_empty", 64'(ifa.empty), 64'h1);
        chk("rst_full", 64'(ifa.full), 64'h0);
        rst_a = 1'b0;

        // Fill 5, 9, 7.
        step_a(1'b1, 1'b0, 8'd5, 12'd1);
        chk("fill1_count", 64'(ifa.count), 64'h1);
        chk("fill1_state", 64'(ifa.state), 64'(OC_PARTIAL));
        chk("fill1_valid", 64'(ifa.valid), 64'b001);
        step_a(1'b1, 1'b0, 8'd9, 12'd2);
        step_a(1'b1, 1'b0, 8'd7, 12'd3);
        chk("fill3_slots", 64'(ifa.slots), 64'h070905);
        chk("fill3_valid", 64'(ifa.valid), 64'b111);
        chk("fill3_count", 64'(ifa.count), 64'h3);
        chk("fill3_full", 64'(ifa.full), 64'h1);
        chk("fill3_empty", 64'(ifa.empty), 64'h0);
        chk("fill3_state", 64'(ifa.state), 64'(OC_FULL));

        // Put into full collector is dropped.
        step_a(1'b1, 1'b0, 8'd4, 12'd4);
        chk("ovf_slots", 64'(ifa.slots), 64'h070905);
        chk("ovf_flag", 64'(ifa.overflow), 64'h1);
        chk("ovf_count", 64'(ifa.count), 64'h3);

        // Op clears valid and overflow, keeps data.
        step_a(1'b0, 1'b1, 8'd0, 12'd5);
        chk("op_valid", 64'(ifa.valid), 64'h0);
        chk("op_ovf", 64'(ifa.overflow), 64'h0);
        chk("op_state", 64'(ifa.state), 64'(OC_EMPTY));
        chk("op_empty", 64'(ifa.empty), 64'h1);
        chk("op_slots_kept", 64'(ifa.slots), 64'h070905);

        // Put held for three cycles at one PC.
        step_a(1'b1, 1'b0, 8'd6, 12'd10);
        step_a(1'b1, 1'b0, 8'd6, 12'd10);
        step_a(1'b1, 1'b0, 8'd6, 12'd10);
`ifdef OPERAND_COLLECTOR_PCGATE_EN
        chk("hold_count", 64'(ifa.count), 64'h1);
        chk("hold_slots", 64'(ifa.slots), 64'h070906);
`else
        chk("hold_count", 64'(ifa.count), 64'h3);
        chk("hold_slots", 64'(ifa.slots), 64'h060606);
`endif

        // Idle event leaves state alone.
        step_a(1'b0, 1'b0, 8'hFF, 12'd11);
`ifdef OPERAND_COLLECTOR_PCGATE_EN
        chk("idle_count", 64'(ifa.count), 64'h1);
`else
        chk("idle_count", 64'(ifa.count), 64'h3);
`endif

        // Two puts, then put+op together.
        step_a(1'b0, 1'b1, 8'd0, 12'd12);
        step_a(1'b1, 1'b0, 8'h11, 12'd1);
        step_a(1'b1, 1'b0, 8'h22, 12'd2);
        chk("pre_combo_count", 64'(ifa.count), 64'h2);
        step_a(1'b1, 1'b1, 8'h2A, 12'd3);
        chk("combo_valid", 64'(ifa.valid), 64'b001);
        chk("combo_slot0", 64'(ifa.slots[7:0]), 64'h2A);
        chk("combo_count", 64'(ifa.count), 64'h1);
        chk("combo_ovf", 64'(ifa.overflow), 64'h0);

        // Reset mid-fill, then put at the same PC as before reset.
        step_a(1'b1, 1'b0, 8'h33, 12'd20);
        step_a(1'b1, 1'b0, 8'h44, 12'd21);
        rst_a = 1'b1;
        step_a(1'b0, 1'b0, 8'h00, 12'd21);
        rst_a = 1'b0;
        chk("midrst_count", 64'(ifa.count), 64'h0);
        chk("midrst_slots", 64'(ifa.slots), 64'h0);
        step_a(1'b1, 1'b0, 8'd3, 12'd21);
        chk("postrst_slot0", 64'(ifa.slots[7:0]), 64'h03);
        chk("postrst_count", 64'(ifa.count), 64'h1);
        chk("postrst_valid", 64'(ifa.valid), 64'b001);

        // PC wrap from all-ones to zero is a change.
        step_a(1'b1, 1'b0, 8'h55, 12'hFFF);
        step_a(1'b1, 1'b0, 8'h66, 12'h000);
        chk("wrap_count", 64'(ifa.count), 64'h3);
        chk("wrap_slots", 64'(ifa.slots), 64'h665503);
        chk("wrap_full", 64'(ifa.full), 64'h1);

        // Single-slot 16-bit instance.
        step_b(1'b0, 1'b0, 16'h0, 12'd0);
        rst_b = 1'b0;
        chk("b_rst_empty", 64'(ifb.empty), 64'h1);
        step_b(1'b1, 1'b0, 16'hBEEF, 12'd1);
        chk("b_full", 64'(ifb.full), 64'h1);
        chk("b_state", 64'(ifb.state), 64'(OC_FULL));
        chk("b_slot0", 64'(ifb.slots), 64'hBEEF);
        step_b(1'b1, 1'b0, 16'h1234, 12'd2);
        chk("b_ovf", 64'(ifb.overflow), 64'h1);
        chk("b_slot0_kept", 64'(ifb.slots), 64'hBEEF);
        chk("b_count", 64'(ifb.count), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each operand slot and of value.
REQ-002 Parameter DEPTH, default 3, number of operand slots; legal range 1..16.
REQ-003 Parameter PC_W, default 12, width of prog_ctr.
REQ-004 clk  input  1  rising-edge clock, sole clock of the block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 put_en  input  1  request to append value into the next free slot.
REQ-007 op_en  input  1  request to consume all slots (clear valid bits).
REQ-008 value  input  WIDTH  operand to append.
REQ-009 prog_ctr  input  PC_W  current program counter; gates event acceptance.
REQ-010 slots  output  DEPTH*WIDTH  slot i at bits [i*WIDTH +: WIDTH].
REQ-011 valid  output  DEPTH  bit i set = slot i holds an operand.
REQ-012 count  output  $clog2(DEPTH+1)  number of valid slots.
REQ-013 full, empty  output  1 each  count==DEPTH, count==0.
REQ-014 overflow  output  1  sticky: a put was dropped because all slots were valid.
REQ-015 state  output  2  collector state, encoded per the package enum.

Function
REQ-016 An event cycle is a rising edge where prog_ctr differs from the last accepted prog_ctr, or the first edge after reset; all other cycles leave all state unchanged.
REQ-017 On every event cycle, prog_ctr is recorded as the last accepted value, whatever the enables.
REQ-018 Put only (put_en=1, op_en=0), not full: value is written to slot index count, its valid bit is set, and count increments.
REQ-019 Put only when full: value is dropped, slots are unchanged, and overflow is set.
REQ-020 Op only: all valid bits clear, count=0, overflow clears; slot data is retained.
REQ-021 Put and op together: the op applies first, then the put; result is valid=...001, slot0=value, count=1, overflow=0.
REQ-022 Neither enable on an event cycle: no change other than the recorded PC.
REQ-023 Slots fill strictly in ascending index order; valid is always a contiguous low-order mask of count ones.
REQ-024 All outputs are registered; an accepted event is visible one cycle after the edge that takes it.
REQ-025 States: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); state always matches count.
REQ-026 When DEPTH=1, the PARTIAL state is unreachable.
REQ-027 A prog_ctr wrap from all-ones to zero counts as a change.

Reset
REQ-028 Reset has priority over all inputs.
REQ-029 Reset values: valid=0, count=0, slots=0, overflow=0, state=EMPTY, empty=1, full=0.
REQ-030 After reset the PC tracker is marked unset, so the first post-reset edge is an event cycle.
REQ-031 Reset asserted mid-fill discards all collected operands; the following put lands in slot 0.

Configuration
REQ-032 Macro OPERAND_COLLECTOR_PCGATE_EN defined: PC-change gating applies per REQ-016/017.
REQ-033 Macro undefined: every non-reset edge is an event cycle, the PC tracker is omitted, and prog_ctr is ignored.

Structure
REQ-034 Package opcol_pkg holds the state enum (OC_EMPTY=0, OC_PARTIAL=1, OC_FULL=2) and the default parameter constants.
REQ-035 Sub-module pc_change_detect (parameter PC_W; ports clk, reset, prog_ctr, new_pc) implements REQ-016/017/030 and is instantiated only under the macro.

Verification
REQ-036 Reset, then puts of 5, 9, 7 at PCs 1, 2, 3: slots={7,9,5}, valid=111, count=3, full=1, state=FULL.
REQ-037 Full, then put of 4 at PC 4: slots unchanged, overflow=1; op at PC 5 gives valid=000, overflow=0, state=EMPTY.
REQ-038 With the macro defined, put of 6 held for 3 cycles at PC 10: exactly one slot filled, count=1; macro undefined: count=3.
REQ-039 Two puts at PCs 1 and 2, then put+op together with value 0x2A at PC 3: valid=001, slot0=0x2A, count=1.
REQ-040 Two puts, then reset for one cycle, then put of 3 at the same PC as before reset: accepted into slot0, count=1.
REQ-041 Parameters WIDTH=16, DEPTH=1: put of 0xBEEF gives full=1; a second put at a new PC sets overflow and leaves slot0=0xBEEF.
